// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache.
// Hits answer one cycle after acceptance from a registered-read data RAM.
// Misses refill a whole line over a single-outstanding memory port and then
// return the requested word. A fetch flush drops the pending miss response.
module icache #(
  parameter int SETS  = 64,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_ic_req,
  input  logic [29:0] fetch_ic_addr,
  input  logic        fetch_ic_flush,
  output logic        icache_ready,
  output logic        icache_valid,
  output logic        icache_error,
  output logic [31:0] icache_data,
  output logic        mem_req,
  output logic [29:0] mem_addr,
  input  logic        mem_ready,
  input  logic        mem_valid,
  input  logic        mem_error,
  input  logic [31:0] mem_data
);

  localparam int OFF_W   = $clog2(WORDS);
  localparam int IDX_W   = $clog2(SETS);
  localparam int TAG_LSB = OFF_W + IDX_W;
  localparam int TAG_W   = 30 - TAG_LSB;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MREQ = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  // Control state
  logic [1:0]       state_q, state_d;
  logic             s1_valid_q, s1_valid_d;
  logic [29:0]      s1_addr_q, s1_addr_d;
  logic [29:0]      miss_addr_q, miss_addr_d;
  logic [OFF_W-1:0] cnt_q, cnt_d;
  logic             drop_q, drop_d;
  logic             err_q, err_d;
  logic [31:0]      resp_data_q, resp_data_d;
  logic [SETS-1:0]  valid_q, valid_d;

  // Storage: tag and data RAMs with registered reads
  logic [TAG_W-1:0] tag_mem [SETS];
  logic [31:0]      data_mem [SETS*WORDS];
  logic [TAG_W-1:0] rtag_q;
  logic [31:0]      rdata_q;

  // Address fields
  logic [TAG_LSB-1:0] req_word;
  logic [IDX_W-1:0]   s1_idx;
  logic [TAG_W-1:0]   s1_tag;
  logic [IDX_W-1:0]   miss_idx;
  logic [TAG_W-1:0]   miss_tag;
  logic [OFF_W-1:0]   miss_off;

  assign req_word = fetch_ic_addr[TAG_LSB-1:0];
  assign s1_idx   = s1_addr_q[TAG_LSB-1:OFF_W];
  assign s1_tag   = s1_addr_q[29:TAG_LSB];
  assign miss_idx = miss_addr_q[TAG_LSB-1:OFF_W];
  assign miss_tag = miss_addr_q[29:TAG_LSB];
  assign miss_off = miss_addr_q[OFF_W-1:0];

  logic s1_hit, s1_miss, accept, fill_beat, fill_last;

  assign s1_hit    = s1_valid_q && valid_q[s1_idx] && (rtag_q == s1_tag);
  assign s1_miss   = s1_valid_q && !s1_hit;
  assign fill_beat = (state_q == S_FILL) && mem_valid;
  assign fill_last = fill_beat && (cnt_q == LAST_BEAT);
  assign accept    = fetch_ic_req && icache_ready && !fetch_ic_flush;

  // Next-state, handshake and response logic
  always_comb begin
    state_d      = state_q;
    s1_valid_d   = s1_valid_q;
    s1_addr_d    = s1_addr_q;
    miss_addr_d  = miss_addr_q;
    cnt_d        = cnt_q;
    drop_d       = drop_q;
    err_d        = err_q;
    resp_data_d  = resp_data_q;
    valid_d      = valid_q;
    icache_ready = 1'b0;
    icache_valid = 1'b0;
    icache_error = 1'b0;
    icache_data  = 32'd0;
    mem_req      = 1'b0;
    mem_addr     = 30'd0;

    case (state_q)
      S_IDLE: begin
        icache_ready = !s1_miss;
        if (accept) begin
          s1_valid_d = 1'b1;
          s1_addr_d  = fetch_ic_addr;
        end else begin
          s1_valid_d = 1'b0;
        end
        if (s1_hit) begin
          icache_valid = 1'b1;
          icache_data  = rdata_q;
        end
        // A flush coinciding with a detected miss aborts it before any memory traffic
        if (s1_miss && !fetch_ic_flush) begin
          valid_d[s1_idx] = 1'b0;
          miss_addr_d     = s1_addr_q;
          drop_d          = 1'b0;
          err_d           = 1'b0;
          state_d         = S_MREQ;
        end
      end
      S_MREQ: begin
        mem_req  = 1'b1;
        mem_addr = {miss_tag, miss_idx, {OFF_W{1'b0}}};
        if (fetch_ic_flush) drop_d = 1'b1;
        if (mem_ready) begin
          cnt_d   = '0;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (fetch_ic_flush) drop_d = 1'b1;
        if (mem_valid) begin
          cnt_d = cnt_q + OFF_W'(1);
          err_d = err_q | mem_error;
          if (cnt_q == miss_off) resp_data_d = mem_data;
          if (cnt_q == LAST_BEAT) begin
            // Only a line with no bad beat becomes usable
            valid_d[miss_idx] = !(err_q || mem_error);
            state_d           = S_RESP;
          end
        end
      end
      default: begin
        if (!drop_q) begin
          icache_valid = 1'b1;
          icache_error = err_q;
          icache_data  = err_q ? 32'd0 : resp_data_q;
        end
        s1_valid_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
  end

  // Control registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      miss_addr_q <= '0;
      cnt_q       <= '0;
      drop_q      <= 1'b0;
      err_q       <= 1'b0;
      resp_data_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      s1_valid_q  <= s1_valid_d;
      s1_addr_q   <= s1_addr_d;
      miss_addr_q <= miss_addr_d;
      cnt_q       <= cnt_d;
      drop_q      <= drop_d;
      err_q       <= err_d;
      resp_data_q <= resp_data_d;
      valid_q     <= valid_d;
    end
  end

  // Tag/data RAMs: refill writes, registered read at the requested address
  always_ff @(posedge clk) begin
    if (fill_beat) data_mem[{miss_idx, cnt_q}] <= mem_data;
    if (fill_last) tag_mem[miss_idx] <= miss_tag;
    rdata_q <= data_mem[req_word];
    rtag_q  <= tag_mem[req_word[TAG_LSB-1:OFF_W]];
  end

endmodule
